// File: rtl/fft_in_pingpong_buf_if.sv
// Bus between the AXI-stream slave writer, the ping-pong input buffer
// and the FFT core. The buffer uses the slave modport; whatever drives
// the writes and the core handshake uses the master modport.
interface fft_in_pingpong_buf_if #(
  parameter int C_FFT_SIZE_LOG2 = 10,
  parameter int C_SAMPLE_WDT    = 16
);

  // write side
  logic                       push;
  logic [C_FFT_SIZE_LOG2-1:0] s_axis_if_addr;
  logic [C_SAMPLE_WDT-1:0]    data_re_0_in;
  logic [C_SAMPLE_WDT-1:0]    data_im_0_in;
  logic                       rx_done;
  logic                       buf_busy;

  // core handshake and read port
  logic                       frame_valid;
  logic                       frame_start;
  logic                       rd_en;
  logic [C_FFT_SIZE_LOG2-1:0] rd_addr;
  logic [C_SAMPLE_WDT-1:0]    rd_data_re;
  logic [C_SAMPLE_WDT-1:0]    rd_data_im;
  logic                       frame_release;

  // sticky error reporting
  logic                       err_ovf;
  logic                       err_short;
  logic                       err_clr;

  modport slave (
    input  push, s_axis_if_addr, data_re_0_in, data_im_0_in, rx_done,
           frame_start, rd_en, rd_addr, frame_release, err_clr,
    output buf_busy, frame_valid, rd_data_re, rd_data_im, err_ovf, err_short
  );

  modport master (
    output push, s_axis_if_addr, data_re_0_in, data_im_0_in, rx_done,
           frame_start, rd_en, rd_addr, frame_release, err_clr,
    input  buf_busy, frame_valid, rd_data_re, rd_data_im, err_ovf, err_short
  );

endinterface

// File: rtl/fft_in_pingpong_buf.sv
// Ping-pong input frame buffer for the FFT core. Incoming samples are
// written at (optionally) bit-reversed addresses into the write bank;
// completed frames are handed to the core via frame_start/frame_release
// while the other bank keeps filling.
module fft_in_pingpong_buf #(
  parameter int C_FFT_SIZE_LOG2 = 10,
  parameter int C_SAMPLE_WDT    = 16,
  parameter int BIT_REV         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_in_pingpong_buf_if.slave  bus
);

  localparam int unsigned LOG2 = C_FFT_SIZE_LOG2;
  localparam int unsigned SW   = C_SAMPLE_WDT;
  localparam int unsigned N    = 1 << LOG2;
  localparam logic [LOG2:0] FRAME_LEN = {1'b1, {LOG2{1'b0}}};

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [LOG2:0]   wr_cnt_q, wr_cnt_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_short_q, err_short_d;
  logic [2*SW-1:0] rd_data_q;

  logic [2*SW-1:0] mem [2*N];

  logic            wr_busy;
  logic            push_ok;
  logic            push_drop;
  logic [LOG2:0]   cnt_upd;
  logic [LOG2-1:0] addr_rev;
  logic [LOG2-1:0] wr_addr;

  // Write-side qualification and bit-reversed write address
  always_comb begin
    addr_rev = '0;
    for (int unsigned i = 0; i < LOG2; i++) begin
      addr_rev[i] = bus.s_axis_if_addr[LOG2-1-i];
    end
    wr_addr   = (BIT_REV != 0) ? addr_rev : bus.s_axis_if_addr;
    wr_busy   = (bank_q[wr_bank_q] == BANK_FULL) ||
                (bank_q[wr_bank_q] == BANK_READING);
    push_ok   = bus.push && !wr_busy && (wr_cnt_q != FRAME_LEN);
    push_drop = bus.push && !push_ok;
    cnt_upd   = wr_cnt_q + {{LOG2{1'b0}}, push_ok};
  end

  // Next-state for bank states, pointers, frame counter and error flags.
  // Write side only touches EMPTY/FILLING banks and the read side only
  // FULL/READING banks, so both may act on the same bank in one cycle.
  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = cnt_upd;
    err_ovf_d   = err_ovf_q;
    err_short_d = err_short_q;

    if (push_ok && (bank_q[wr_bank_q] == BANK_EMPTY)) begin
      bank_d[wr_bank_q] = BANK_FILLING;
    end

    // rx_done sees the count including a same-cycle push
    if (bus.rx_done) begin
      wr_cnt_d = '0;
      if (cnt_upd == FRAME_LEN) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        if (!wr_busy) begin
          bank_d[wr_bank_q] = BANK_EMPTY;
        end
        err_short_d = 1'b1;
      end
    end

    if (bus.frame_start && (bank_q[rd_bank_q] == BANK_FULL)) begin
      bank_d[rd_bank_q] = BANK_READING;
    end

    if (bus.frame_release && (bank_q[rd_bank_q] == BANK_READING)) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end

    if (push_drop) begin
      err_ovf_d = 1'b1;
    end

    if (bus.err_clr) begin
      err_ovf_d   = 1'b0;
      err_short_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_short_q <= err_short_d;
    end
  end

  // Sample storage write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[{wr_bank_q, wr_addr}] <= {bus.data_re_0_in, bus.data_im_0_in};
    end
  end

  // Registered read port from the current read bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= mem[{rd_bank_q, bus.rd_addr}];
    end
  end

  assign bus.buf_busy    = wr_busy;
  assign bus.frame_valid = (bank_q[rd_bank_q] == BANK_FULL);
  assign bus.rd_data_re  = rd_data_q[2*SW-1:SW];
  assign bus.rd_data_im  = rd_data_q[SW-1:0];
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_short   = err_short_q;

endmodule
